alu_res_tx: RTL and testbench

- Downstream neighbour of the 4-bit ALU stage.
- Accepts each registered 10-bit result and its carry over the existing res_valid/res_ready handshake, buffers results in a small FIFO, and emits each one as two byte beats on an 8-bit output with its own valid/ready handshake.
- Drives the chip's dedicated output byte.
- Tags every result with a wrapping 3-bit sequence number and a zero flag.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_res_tx_if.sv | 23 ++
 rtl/alu_res_tx_fifo.sv | 47 ++++
 rtl/alu_res_tx.sv | 91 +++++++++
 tb/tb_alu_res_tx.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result transmitter.
// The HI-beat parity bit is only built when ALU_TX_PARITY_EN is defined.
package alu_pkg;

  localparam int RES_W = 10;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LO,
    TX_HI
  } tx_state_t;

  // Bit positions of the fields inside the HI beat
  localparam int HI_PAR     = 7;
  localparam int HI_SEQ_LSB = 4;
  localparam int HI_ZERO    = 3;
  localparam int HI_CARRY   = 2;
  localparam int HI_RES_LSB = 0;

  typedef struct packed {
    logic             carry;
    logic [RES_W-1:0] res;
  } res_entry_t;

endpackage

// File: rtl/alu_res_tx_if.sv
// Handshake bundle between the ALU stage, this transmitter and the byte sink.
interface alu_res_tx_if;
  logic [9:0] res_i;
  logic       carry_i;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  // Environment side: produces results, consumes beats
  modport master (
    output res_i, carry_i, res_valid, out_ready,
    input  res_ready, out_data, out_valid, busy
  );

  // Transmitter side
  modport slave (
    input  res_i, carry_i, res_valid, out_ready,
    output res_ready, out_data, out_valid, busy
  );
endinterface

// File: rtl/alu_res_tx_fifo.sv
// Small result FIFO: registered storage, pointers one bit wider than the
// address so full and empty are told apart by the top pointer bit.
module res_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic         last
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  count;

  // Pointer update; caller never pushes when full nor pops when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage, no reset needed since empty gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign last  = (count == (AW+1)'(1));

endmodule

// File: rtl/alu_res_tx.sv
// ALU result transmitter: buffers {carry, res} entries and sends each as a
// LO byte (res[7:0]) then a HI byte {P, seq, zero, carry, res[9:8]}.
// Define ALU_TX_PARITY_EN to fill P with even parity over the frame.
module alu_res_tx
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int SEQ_W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_res_tx_if.slave  bus
);

  tx_state_t        state_q, state_d;
  res_entry_t       in_e, head;
  logic             full, empty, last;
  logic             push, pop;
  logic [SEQ_W-1:0] seq;
  logic             zero;
  logic [7:0]       hi_beat;

  assign in_e = {bus.carry_i, bus.res_i};
  assign push = bus.res_valid & ~full;
  assign pop  = (state_q == TX_HI) & bus.out_ready;

  res_fifo #(.DEPTH(DEPTH), .W($bits(res_entry_t))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (in_e),
    .head  (head),
    .full  (full),
    .empty (empty),
    .last  (last)
  );

  // State and sequence counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      seq     <= '0;
    end else begin
      state_q <= state_d;
      if (pop) seq <= seq + 1'b1;
    end
  end

  // Next state; a same-cycle push keeps HI flowing straight into LO
  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE: if (!empty)        state_d = TX_LO;
      TX_LO:   if (bus.out_ready) state_d = TX_HI;
      TX_HI:   if (bus.out_ready) state_d = (last && !push) ? TX_IDLE : TX_LO;
      default:                    state_d = TX_IDLE;
    endcase
  end

  assign zero = (head.res == '0);

  // HI beat field packing
  always_comb begin
    hi_beat = '0;
    hi_beat[HI_RES_LSB +: 2]     = head.res[9:8];
    hi_beat[HI_CARRY]            = head.carry;
    hi_beat[HI_ZERO]             = zero;
    hi_beat[HI_SEQ_LSB +: SEQ_W] = seq;
`ifdef ALU_TX_PARITY_EN
    hi_beat[HI_PAR]              = ^{head, seq, zero};
`else
    hi_beat[HI_PAR]              = 1'b0;
`endif
  end

  // Beat mux; data is forced to zero whenever no beat is offered
  always_comb begin
    bus.out_data = 8'h00;
    case (state_q)
      TX_LO:   bus.out_data = head.res[7:0];
      TX_HI:   bus.out_data = hi_beat;
      default: bus.out_data = 8'h00;
    endcase
  end

  assign bus.out_valid = (state_q != TX_IDLE);
  assign bus.res_ready = ~full;
  assign bus.busy      = ~empty | (state_q != TX_IDLE);

endmodule

// File: tb/tb_alu_res_tx.sv
// Scoreboard bench for alu_res_tx: the driver queues expected beats as it
// issues results; an independent monitor pops and compares accepted beats.
module tb_alu_res_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_res_tx_if bus();

  alu_res_tx #(.DEPTH(2), .SEQ_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  logic [2:0] mseq = 3'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference HI beat built straight from the field definitions
  function automatic logic [7:0] model_hi(input logic [9:0] r, input logic c, input logic [2:0] s);
    logic z;
    logic p;
    z = (r == 10'd0);
    p = 1'b0;
`ifdef ALU_TX_PARITY_EN
    p = ^{c, r, s, z};
`endif
    return {p, s, z, c, r[9:8]};
  endfunction

  task automatic expect_frame(input logic [9:0] r, input logic [7:0] hi);
    exp_q.push_back(r[7:0]);
    exp_q.push_back(hi);
    mseq = mseq + 3'd1;
  endtask

  task automatic push(input logic [9:0] r, input logic c, input logic [7:0] hi);
    bit ok;
    ok = 0;
    expect_frame(r, hi);
    bus.res_i     = r;
    bus.carry_i   = c;
    bus.res_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.res_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: res_ready stayed 0 required 1");
    end
    @(posedge clk);
    #1 bus.res_valid = 1'b0;
  endtask

  // Wait for all queued beats, then busy must be down one cycle later
  task automatic drain(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check({name, "_drained"}, 32'(ok), 32'd1);
    @(negedge clk);
    check({name, "_busy_low"}, 32'(bus.busy), 32'd0);
    check({name, "_valid_low"}, 32'(bus.out_valid), 32'd0);
  endtask

  // Monitor: compare every accepted beat against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got %0h required none", bus.out_data);
        end else begin
          check("beat", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
      end else if (!bus.out_valid) begin
        check("idle_data", 32'(bus.out_data), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.res_i     = '0;
    bus.carry_i   = 1'b0;
    bus.res_valid = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values
    #3;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    #19 rst_n = 1'b1;
    #1 check("rst_ready", 32'(bus.res_ready), 32'd1);
    @(posedge clk);
    #1;

    // Case 1: latency and beat contents
    push(10'h2A5, 1'b1, 8'h06);
    @(negedge clk);
    check("c1_idle_before", 32'(bus.out_valid), 32'd0);
    check("c1_ready", 32'(bus.res_ready), 32'd1);
    @(negedge clk);
    check("c1_lo_valid", 32'(bus.out_valid), 32'd1);
    check("c1_lo", 32'(bus.out_data), 32'hA5);
    @(negedge clk);
    check("c1_hi_valid", 32'(bus.out_valid), 32'd1);
    check("c1_hi", 32'(bus.out_data), 32'h06);
    @(negedge clk);
    check("c1_busy_low", 32'(bus.busy), 32'd0);
    check("c1_valid_low", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Case 2: zero result, seq 1
    push(10'h000, 1'b0, 8'h18);
    drain("c2");
    @(posedge clk);
    #1;

    // Case 3: res 1, seq 2
    push(10'h001, 1'b0, 8'h20);
    drain("c3");

    // Case 4: backpressure with a full FIFO
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    expect_frame(10'h155, 8'h31);
    expect_frame(10'h0F0, 8'h44);
    expect_frame(10'h300, 8'h53);
    bus.res_valid = 1'b1;
    bus.res_i = 10'h155; bus.carry_i = 1'b0;
    @(posedge clk);
    #1 bus.res_i = 10'h0F0; bus.carry_i = 1'b1;
    @(posedge clk);
    #1 bus.res_i = 10'h300; bus.carry_i = 1'b0;
    @(negedge clk);
    check("c4_full_ready", 32'(bus.res_ready), 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("c4_stall_valid", 32'(bus.out_valid), 32'd1);
      check("c4_stall_data", 32'(bus.out_data), 32'h55);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("c4_drain_valid", 32'(bus.out_valid), (k < 6) ? 32'd1 : 32'd0);
      if (bus.res_valid && bus.res_ready) begin
        @(posedge clk);
        #1 bus.res_valid = 1'b0;
      end
    end
    check("c4_third_taken", 32'(bus.res_valid), 32'd0);
    check("c4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Case 6: reset while in HI with another entry queued
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    push(10'h0AA, 1'b0, model_hi(10'h0AA, 1'b0, mseq));
    push(10'h123, 1'b1, model_hi(10'h123, 1'b1, mseq));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("c6_in_hi_valid", 32'(bus.out_valid), 32'd1);
    check("c6_in_hi_data", 32'(bus.out_data), 32'(model_hi(10'h0AA, 1'b0, 3'd6)));
    #2 rst_n = 1'b0;
    #1;
    check("c6_rst_valid", 32'(bus.out_valid), 32'd0);
    check("c6_rst_data", 32'(bus.out_data), 32'd0);
    check("c6_rst_busy", 32'(bus.busy), 32'd0);
    exp_q.delete();
    mseq = 3'd0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("c6_rel_busy", 32'(bus.busy), 32'd0);
    check("c6_rel_ready", 32'(bus.res_ready), 32'd1);
    check("c6_rel_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Case 5: nine results from seq 0; the ninth wraps back to seq 0
    for (int i = 0; i < 8; i++) begin
      logic [9:0] r;
      r = 10'(i * 37 + 5);
      push(r, i[0], model_hi(r, i[0], mseq));
    end
    check("c5_seq_wrapped", 32'(mseq), 32'd0);
    push(10'h3FF, 1'b1, model_hi(10'h3FF, 1'b1, 3'd0));
    drain("c5");

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
